// File: rtl/swan256_pkg.sv
// Shared SWAN256 definitions: block geometry, controller state encoding and the
// word-select helper used by the stream front-end.
package swan256_pkg;

   localparam int SWAN_BLOCK_W = 256;
   localparam int SWAN_KEY_W   = 256;
   localparam int SWAN_WORD_W  = 32;
   localparam int SWAN_WORDS   = 8;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      KICK    = 2'd1,
      WAIT    = 2'd2,
      EMIT    = 2'd3
   } swan_state_e;

   // Word 0 sits in the most significant 32 bits of the block.
   function automatic logic [SWAN_WORD_W-1:0] swan_word(input logic [SWAN_BLOCK_W-1:0] blk,
                                                         input logic [2:0] idx);
      case (idx)
         3'd0:    return blk[255:224];
         3'd1:    return blk[223:192];
         3'd2:    return blk[191:160];
         3'd3:    return blk[159:128];
         3'd4:    return blk[127:96];
         3'd5:    return blk[95:64];
         3'd6:    return blk[63:32];
         3'd7:    return blk[31:0];
         default: return {SWAN_WORD_W{1'b0}};
      endcase
   endfunction

endpackage

// File: rtl/swan256_word_pack.sv
// 256-bit block register with a 3-bit word index: packs words in one at a time,
// or loads a whole block and steps the index to read it out word by word.
module swan256_word_pack
   import swan256_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    wr_word,
   input  logic [SWAN_WORD_W-1:0]  word_in,
   input  logic                    load_par,
   input  logic [SWAN_BLOCK_W-1:0] par_in,
   input  logic                    shift,
   output logic [SWAN_BLOCK_W-1:0] data,
   output logic [2:0]              idx
);

   logic [SWAN_BLOCK_W-1:0] data_r;
   logic [2:0]              idx_r;

   // Block storage and word index; the index wraps to 0 after word 7.
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_r <= {SWAN_BLOCK_W{1'b0}};
         idx_r  <= 3'd0;
      end else if (load_par) begin
         data_r <= par_in;
         idx_r  <= 3'd0;
      end else if (wr_word) begin
         for (int k = 0; k < SWAN_WORDS; k++) begin
            if (idx_r == 3'(k)) begin
               data_r[SWAN_BLOCK_W-1-k*SWAN_WORD_W -: SWAN_WORD_W] <= word_in;
            end
         end
         idx_r <= idx_r + 3'd1;
      end else if (shift) begin
         idx_r <= idx_r + 3'd1;
      end else if (clr) begin
         idx_r <= 3'd0;
      end else begin
         idx_r <= idx_r;
      end
   end

   assign data = data_r;
   assign idx  = idx_r;

endmodule

// File: rtl/swan256_stream_ctrl.sv
// Word-stream front-end for a SWAN256 cipher core: packs 8 words, kicks the core,
// waits under a watchdog, then unpacks the 256-bit result into 8 output words.
module swan256_stream_ctrl
   import swan256_pkg::*;
#(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SWAN_KEY_W-1:0]   key_in,
   input  logic                    key_load,
   input  logic [SWAN_WORD_W-1:0]  s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic [SWAN_WORD_W-1:0]  m_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    core_start,
   output logic [SWAN_KEY_W-1:0]   core_key,
   output logic [SWAN_BLOCK_W-1:0] core_inp,
   input  logic                    core_ready,
   input  logic [SWAN_BLOCK_W-1:0] core_out,
   output logic                    timeout_err,
   output logic [CNT_W-1:0]        blk_cnt
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   swan_state_e             state_r, state_s;
   logic [WD_W-1:0]         wdog_r;
   logic [SWAN_KEY_W-1:0]   key_r;
   logic                    s_ready_r, m_valid_r, core_start_r, timeout_err_r;
   logic [CNT_W-1:0]        blk_cnt_r;
   logic                    in_wr_s, in_clr_s, out_load_s, out_shift_s, expire_s, blk_done_s;
   logic [2:0]              in_idx_s, out_idx_s;
   logic [SWAN_BLOCK_W-1:0] out_blk_s;

   // Next-state and datapath strobes; core_ready beats watchdog expiry in WAIT.
   always_comb begin
      state_s     = state_r;
      in_wr_s     = 1'b0;
      in_clr_s    = 1'b0;
      out_load_s  = 1'b0;
      out_shift_s = 1'b0;
      expire_s    = 1'b0;
      blk_done_s  = 1'b0;
      case (state_r)
         COLLECT: begin
            in_wr_s = s_valid & s_ready_r;
            if (s_valid && s_ready_r && in_idx_s == 3'd7) begin
               state_s = KICK;
            end else begin
               state_s = COLLECT;
            end
         end
         KICK: begin
            state_s = WAIT;
         end
         WAIT: begin
            if (core_ready) begin
               out_load_s = 1'b1;
               state_s    = EMIT;
            end else if (wdog_r == WD_W'(TIMEOUT - 1)) begin
               expire_s = 1'b1;
               in_clr_s = 1'b1;
               state_s  = COLLECT;
            end else begin
               state_s = WAIT;
            end
         end
         EMIT: begin
            if (m_ready) begin
               out_shift_s = 1'b1;
               if (out_idx_s == 3'd7) begin
                  blk_done_s = 1'b1;
                  state_s    = COLLECT;
               end else begin
                  state_s = EMIT;
               end
            end else begin
               state_s = EMIT;
            end
         end
         default: begin
            state_s = COLLECT;
         end
      endcase
   end

   // State, registered handshake outputs, watchdog, key, error flag and block counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r       <= COLLECT;
         s_ready_r     <= 1'b1;
         m_valid_r     <= 1'b0;
         core_start_r  <= 1'b0;
         wdog_r        <= {WD_W{1'b0}};
         key_r         <= {SWAN_KEY_W{1'b0}};
         timeout_err_r <= 1'b0;
         blk_cnt_r     <= {CNT_W{1'b0}};
      end else begin
         state_r      <= state_s;
         s_ready_r    <= (state_s == COLLECT);
         m_valid_r    <= (state_s == EMIT);
         core_start_r <= (state_s == KICK);
         if (state_r == KICK) begin
            wdog_r <= {WD_W{1'b0}};
         end else if (state_r == WAIT) begin
            wdog_r <= wdog_r + WD_W'(1);
         end else begin
            wdog_r <= wdog_r;
         end
         // Key only moves while collecting, so it is frozen for the core's run.
         if (state_r == COLLECT && key_load) begin
            key_r <= key_in;
         end else begin
            key_r <= key_r;
         end
         timeout_err_r <= timeout_err_r | expire_s;
         if (blk_done_s) begin
            blk_cnt_r <= blk_cnt_r + CNT_W'(1);
         end else begin
            blk_cnt_r <= blk_cnt_r;
         end
      end
   end

   swan256_word_pack u_in_pack (
      .clk      (clk),
      .rst      (rst),
      .clr      (in_clr_s),
      .wr_word  (in_wr_s),
      .word_in  (s_data),
      .load_par (1'b0),
      .par_in   ({SWAN_BLOCK_W{1'b0}}),
      .shift    (1'b0),
      .data     (core_inp),
      .idx      (in_idx_s)
   );

   swan256_word_pack u_out_pack (
      .clk      (clk),
      .rst      (rst),
      .clr      (1'b0),
      .wr_word  (1'b0),
      .word_in  ({SWAN_WORD_W{1'b0}}),
      .load_par (out_load_s),
      .par_in   (core_out),
      .shift    (out_shift_s),
      .data     (out_blk_s),
      .idx      (out_idx_s)
   );

   assign s_ready     = s_ready_r;
   assign m_valid     = m_valid_r;
   assign m_data      = swan_word(out_blk_s, out_idx_s);
   assign core_start  = core_start_r;
   assign core_key    = key_r;
   assign timeout_err = timeout_err_r;
   assign blk_cnt     = blk_cnt_r;

endmodule

// File: tb/tb_swan256_stream_ctrl.sv
// Randomized scoreboard bench for swan256_stream_ctrl with a stub cipher core of
// programmable latency and a block-level reference model.
module tb_swan256_stream_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [255:0] key_in = '0;
   logic         key_load = 1'b0;
   logic [31:0]  s_data = '0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [31:0]  m_data;
   logic         m_valid;
   logic         m_ready = 1'b0;
   logic         core_start;
   logic [255:0] core_key;
   logic [255:0] core_inp;
   logic         core_ready = 1'b0;
   logic [255:0] core_out = '0;
   logic         timeout_err;
   logic [15:0]  blk_cnt;

   int           checks = 0;
   int           errors = 0;
   logic [31:0]  exp_q[$];
   logic [255:0] model_key = '0;
   int           model_blks = 0;
   int           cur_lat = 1;
   int           stall_pct = 0;
   bit           mon_en = 1'b0;

   swan256_stream_ctrl #(.TIMEOUT(16), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .core_start(core_start), .core_key(core_key), .core_inp(core_inp),
      .core_ready(core_ready), .core_out(core_out),
      .timeout_err(timeout_err), .blk_cnt(blk_cnt)
   );

   always #5 clk = ~clk;

   // Stand-in cipher: any fixed keyed mixing function will do for the controller.
   function automatic logic [255:0] core_fn(input logic [255:0] b, input logic [255:0] k);
      return (b ^ k) + {b[127:0], b[255:128]};
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Stub core: answers lat cycles into WAIT (lat 0 = never), otherwise throws junk readies in COLLECT.
   initial begin
      logic [255:0] res;
      forever begin
         @(negedge clk);
         core_ready = 1'b0;
         core_out   = rand256();
         if (core_start) begin
            res = core_fn(core_inp, core_key);
            if (cur_lat != 0) begin
               repeat (cur_lat) @(negedge clk);
               core_ready = 1'b1;
               core_out   = res;
            end
         end else if (s_ready && mon_en && $urandom_range(0, 3) == 0) begin
            core_ready = 1'b1;
         end
      end
   end

   // Monitor: random m_ready, scoreboard pop on handshake, stability check while stalled.
   initial begin
      bit          stalled = 1'b0;
      logic [31:0] held = '0;
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            stalled = 1'b0;
            m_ready = 1'b0;
         end else begin
            if (stalled) begin
               check("stall_valid", 256'(m_valid), 256'(1));
               check("stall_data", 256'(m_data), 256'(held));
            end
            m_ready = ($urandom_range(0, 99) >= stall_pct);
            if (m_valid && m_ready) begin
               stalled = 1'b0;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL m_unexpected actual=%0h required=none", m_data);
               end else begin
                  e = exp_q.pop_front();
                  check("m_data", 256'(m_data), 256'(e));
               end
            end else if (m_valid) begin
               stalled = 1'b1;
               held    = m_data;
            end else begin
               stalled = 1'b0;
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b0;
      mon_en   = 1'b0;
      s_valid  = 1'b0;
      key_load = 1'b0;
      exp_q.delete();
      model_key  = '0;
      model_blks = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_s_ready", 256'(s_ready), 256'(1));
      check("rst_m_valid", 256'(m_valid), 256'(0));
      check("rst_core_start", 256'(core_start), 256'(0));
      check("rst_timeout_err", 256'(timeout_err), 256'(0));
      check("rst_blk_cnt", 256'(blk_cnt), 256'(0));
      check("rst_core_key", core_key, 256'(0));
      check("rst_core_inp", core_inp, 256'(0));
      check("rst_m_data", 256'(m_data), 256'(0));
      mon_en = 1'b1;
   endtask

   // Offers n words with random gaps; optional key load rides on word 0.
   task automatic send_words(input logic [31:0] w[8], input int n, input bit do_key);
      logic [255:0] nk;
      int           b;
      nk = rand256();
      for (int k = 0; k < n; k++) begin
         s_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         s_valid = 1'b1;
         s_data  = w[k];
         if (k == 0 && do_key) begin
            key_load = 1'b1;
            key_in   = nk;
         end
         b = 0;
         while (!s_ready && b < 100) begin
            @(negedge clk);
            b++;
         end
         if (b >= 100) check("s_ready_wait", 256'(s_ready), 256'(1));
         @(negedge clk);
         key_load = 1'b0;
      end
      s_valid = 1'b0;
      if (do_key && n > 0) model_key = nk;
   endtask

   task automatic run_block(input int lat, input bit do_key, input bit wait_key, input bit abort_emit);
      logic [31:0]  w[8];
      logic [255:0] blk, r;
      int           t;
      bit           expect_to;
      for (int k = 0; k < 8; k++) w[k] = $urandom;
      cur_lat = lat;
      expect_to = (lat == 0 || lat > 16);
      send_words(w, 8, do_key);
      blk = {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]};
      r   = core_fn(blk, model_key);
      check("kick_after_word7", 256'(core_start), 256'(1));
      check("core_inp", core_inp, blk);
      check("core_key", core_key, model_key);
      if (!expect_to) begin
         for (int j = 0; j < 8; j++) exp_q.push_back(r[255-32*j -: 32]);
      end
      t = 0;
      @(negedge clk);
      t++;
      check("start_one_cycle", 256'(core_start), 256'(0));
      if (wait_key) begin
         key_load = 1'b1;
         key_in   = rand256();
         @(negedge clk);
         t++;
         key_load = 1'b0;
      end
      if (expect_to) begin
         while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
         end
         check("timeout_lat", 256'(t), 256'(17));
         check("timeout_err", 256'(timeout_err), 256'(1));
         check("timeout_no_emit", 256'(m_valid), 256'(0));
      end else begin
         while (!m_valid && t < 100) begin
            @(negedge clk);
            t++;
         end
         check("m_valid_lat", 256'(t), 256'(lat + 1));
         if (abort_emit) begin
            repeat (2) @(negedge clk);
         end else begin
            t = 0;
            while (exp_q.size() != 0 && t < 400) begin
               @(negedge clk);
               t++;
            end
            check("emit_drained", 256'(exp_q.size()), 256'(0));
            @(negedge clk);
            model_blks++;
            check("blk_cnt", 256'(blk_cnt), 256'(model_blks[15:0]));
            check("idle_s_ready", 256'(s_ready), 256'(1));
            check("idle_m_valid", 256'(m_valid), 256'(0));
         end
      end
   endtask

   initial begin
      logic [31:0] w[8];
      do_reset();
      stall_pct = 0;
      run_block(3, 1'b0, 1'b0, 1'b0);
      run_block(1, 1'b1, 1'b0, 1'b0);
      stall_pct = 50;
      run_block(5, 1'b0, 1'b1, 1'b0);
      run_block(2, 1'b0, 1'b0, 1'b0);
      run_block(17, 1'b0, 1'b0, 1'b0);
      run_block(4, 1'b1, 1'b0, 1'b0);
      run_block(16, 1'b0, 1'b0, 1'b0);
      run_block(0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         stall_pct = $urandom_range(0, 70);
         run_block($urandom_range(1, 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end
      for (int k = 0; k < 8; k++) w[k] = $urandom;
      send_words(w, 5, 1'b1);
      do_reset();
      stall_pct = 60;
      run_block(3, 1'b1, 1'b0, 1'b1);
      do_reset();
      stall_pct = 30;
      run_block(2, 1'b0, 1'b0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
